// File: rtl/periph_test_sequencer_pkg.sv
// rtl/periph_test_sequencer_pkg.sv - shared types and constants for the peripheral test sequencer
package periph_test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE_DATA,
        ST_WRITE_CTRL,
        ST_POLL,
        ST_READ_DATA,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_FULL      = 2'b00,
        MODE_TX_ONLY   = 2'b01,
        MODE_READ_ONLY = 2'b10,
        MODE_FULL_ALT  = 2'b11
    } mode_t;

    localparam logic [31:0] DEFAULT_CTRL_WORD = 32'h0000_0FD1;

    // Test pattern byte for word idx: (idx + seed) mod 256
    function automatic logic [7:0] pattern8(input logic [31:0] idx, input logic [31:0] seed);
        logic [31:0] sum;
        sum = idx + seed;
        return sum[7:0];
    endfunction

endpackage

// File: rtl/periph_test_sequencer_hold_counter.sv
// rtl/periph_test_sequencer_hold_counter.sv - cycle counter with load and terminal-count expire
module hold_counter #(
    parameter int TERM = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int W = $clog2(TERM + 1);

    logic [W-1:0] cnt;

    // load restarts the count so the cycle after a load is cycle 0 of a new hold
    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = (cnt == W'(TERM - 1));

endmodule

// File: rtl/periph_test_sequencer.sv
// rtl/periph_test_sequencer.sv - write/poll/readback test sequencer for a register-mapped peripheral
module periph_test_sequencer
    import periph_test_sequencer_pkg::*;
#(
    parameter int          DEPTH        = 256,
    parameter int          DATA_W       = 32,
    parameter int          WR_HOLD      = 10,
    parameter int          RD_HOLD      = 10,
    parameter logic [31:0] CTRL_WORD    = DEFAULT_CTRL_WORD,
    parameter int          BUSY_BIT     = 0,
    parameter int          POLL_TIMEOUT = 4096,
    parameter int          SEED         = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] salida_i,
    output logic              wr_i,
    output logic              reg_sel_i,
    output logic [DATA_W-1:0] entrada_i,
    output logic [31:0]       addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [15:0]       err_count_o
);

    localparam int             IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

    state_t        state;
    mode_t         mode;
    logic [IW-1:0] idx;

    logic wr_exp, rd_exp, poll_exp;
    logic wr_load, rd_load, poll_load;

    function automatic logic [DATA_W-1:0] pat(input logic [IW-1:0] i);
        return DATA_W'(pattern8(32'(i), 32'(SEED)));
    endfunction

    // Hold counters sit at zero outside their state and restart at every word boundary
    always_comb begin
        wr_load   = 1'b1;
        rd_load   = 1'b1;
        poll_load = 1'b1;
        if (state == ST_WRITE_DATA || state == ST_WRITE_CTRL) wr_load = wr_exp;
        if (state == ST_READ_DATA) rd_load = rd_exp;
        if (state == ST_POLL) poll_load = 1'b0;
    end

    hold_counter #(.TERM(WR_HOLD)) u_wr_hold (
        .clk    (clk_i),
        .reset  (reset_i),
        .load   (wr_load),
        .expire (wr_exp)
    );

    hold_counter #(.TERM(RD_HOLD)) u_rd_hold (
        .clk    (clk_i),
        .reset  (reset_i),
        .load   (rd_load),
        .expire (rd_exp)
    );

    hold_counter #(.TERM(POLL_TIMEOUT)) u_poll_hold (
        .clk    (clk_i),
        .reset  (reset_i),
        .load   (poll_load),
        .expire (poll_exp)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            mode        <= MODE_FULL;
            idx         <= '0;
            wr_i        <= 1'b0;
            reg_sel_i   <= 1'b0;
            entrada_i   <= '0;
            addr_i      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mode        <= mode_t'(mode_i);
                        err_count_o <= '0;
                        timeout_o   <= 1'b0;
                        busy_o      <= 1'b1;
                        idx         <= '0;
                        addr_i      <= '0;
                        reg_sel_i   <= 1'b1;
                        if (mode_i == MODE_READ_ONLY) begin
                            state     <= ST_READ_DATA;
                            wr_i      <= 1'b0;
                            entrada_i <= '0;
                        end else begin
                            state     <= ST_WRITE_DATA;
                            wr_i      <= 1'b1;
                            entrada_i <= pat('0);
                        end
                    end
                end
                ST_WRITE_DATA: begin
                    if (wr_exp) begin
                        if (idx == LAST) begin
                            state     <= ST_WRITE_CTRL;
                            idx       <= '0;
                            addr_i    <= '0;
                            reg_sel_i <= 1'b0;
                            entrada_i <= DATA_W'(CTRL_WORD);
                        end else begin
                            idx       <= idx + IW'(1);
                            addr_i    <= 32'(idx) + 32'd1;
                            entrada_i <= pat(idx + IW'(1));
                        end
                    end
                end
                ST_WRITE_CTRL: begin
                    if (wr_exp) begin
                        state     <= ST_POLL;
                        wr_i      <= 1'b0;
                        entrada_i <= '0;
                    end
                end
                ST_POLL: begin
                    if (!salida_i[BUSY_BIT]) begin
                        if (mode == MODE_TX_ONLY) begin
                            state     <= ST_DONE;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
                        end else begin
                            state     <= ST_READ_DATA;
                            reg_sel_i <= 1'b1;
                            addr_i    <= '0;
                            idx       <= '0;
                        end
                    end else if (poll_exp) begin
                        // Peripheral never went idle: readback would be meaningless
                        state     <= ST_DONE;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end
                end
                ST_READ_DATA: begin
                    if (rd_exp) begin
                        if (salida_i != pat(idx) && err_count_o != 16'hFFFF) begin
                            err_count_o <= err_count_o + 16'd1;
                        end
                        if (idx == LAST) begin
                            state     <= ST_DONE;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
                            reg_sel_i <= 1'b0;
                            addr_i    <= '0;
                            idx       <= '0;
                        end else begin
                            idx    <= idx + IW'(1);
                            addr_i <= 32'(idx) + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_test_sequencer.sv
// tb/tb_periph_test_sequencer.sv - directed self-checking bench for periph_test_sequencer
module tb_periph_test_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DUT A: DEPTH=4, holds of 3, poll timeout 16, seed 0
    logic        a_reset, a_start;
    logic [1:0]  a_mode;
    logic [31:0] a_salida;
    logic        a_wr, a_rsel;
    logic [31:0] a_entrada, a_addr;
    logic        a_busy, a_done, a_timeout;
    logic [15:0] a_err;

    periph_test_sequencer #(
        .DEPTH(4), .DATA_W(32), .WR_HOLD(3), .RD_HOLD(3), .CTRL_WORD(32'h0000_0FD1),
        .BUSY_BIT(0), .POLL_TIMEOUT(16), .SEED(0)
    ) dut_a (
        .clk_i(clk), .reset_i(a_reset), .start_i(a_start), .mode_i(a_mode),
        .salida_i(a_salida), .wr_i(a_wr), .reg_sel_i(a_rsel), .entrada_i(a_entrada),
        .addr_i(a_addr), .busy_o(a_busy), .done_o(a_done), .timeout_o(a_timeout),
        .err_count_o(a_err)
    );

    // DUT B: DEPTH=32, seed F0, read-only scenarios
    logic        b_reset, b_start;
    logic [1:0]  b_mode;
    logic [31:0] b_salida;
    logic        b_wr, b_rsel;
    logic [31:0] b_entrada, b_addr;
    logic        b_busy, b_done, b_timeout;
    logic [15:0] b_err;

    periph_test_sequencer #(
        .DEPTH(32), .DATA_W(32), .WR_HOLD(2), .RD_HOLD(2), .CTRL_WORD(32'h0000_0FD1),
        .BUSY_BIT(0), .POLL_TIMEOUT(16), .SEED(8'hF0)
    ) dut_b (
        .clk_i(clk), .reset_i(b_reset), .start_i(b_start), .mode_i(b_mode),
        .salida_i(b_salida), .wr_i(b_wr), .reg_sel_i(b_rsel), .entrada_i(b_entrada),
        .addr_i(b_addr), .busy_o(b_busy), .done_o(b_done), .timeout_o(b_timeout),
        .err_count_o(b_err)
    );

    // Peripheral model A: echoes data writes, busy for 5 cycles after a control write
    logic [31:0] mem_a [0:255];
    int          busy_cnt = 0;
    bit          stuck_busy = 1'b0;
    int          corrupt_addr = -1;

    always @(posedge clk) begin
        if (a_wr && a_rsel) mem_a[a_addr[7:0]] <= a_entrada;
        if (a_wr && !a_rsel) busy_cnt <= 5;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always_comb begin
        a_salida = {31'b0, (stuck_busy || busy_cnt != 0)};
        if (a_rsel) a_salida = mem_a[a_addr[7:0]] ^ ((int'(a_addr) == corrupt_addr) ? 32'h0000_0100 : 32'h0);
    end

    logic [31:0] mem_b [0:255];
    always_comb begin
        b_salida = 32'h0;
        if (b_rsel) b_salida = mem_b[b_addr[7:0]];
    end

    // Bus monitors; expected address/data per cycle k is word k/HOLD
    int a_wr_n, a_wr_bad, a_ctrl_n, a_ctrl_bad, a_rd_n, a_rd_bad, a_poll_n, a_done_n;
    int b_wr_n, b_rd_n, b_rd_bad, b_done_n;

    always @(negedge clk) begin
        if (a_wr && a_rsel) begin
            if (a_addr !== 32'(a_wr_n / 3) || a_entrada !== 32'(a_wr_n / 3)) a_wr_bad++;
            a_wr_n++;
        end
        if (a_wr && !a_rsel) begin
            if (a_addr !== 32'h0 || a_entrada !== 32'h0000_0FD1) a_ctrl_bad++;
            a_ctrl_n++;
        end
        if (!a_wr && a_rsel) begin
            if (a_addr !== 32'(a_rd_n / 3) || a_entrada !== 32'h0) a_rd_bad++;
            a_rd_n++;
        end
        if (a_busy && !a_wr && !a_rsel) a_poll_n++;
        if (a_done) a_done_n++;
        if (b_wr) b_wr_n++;
        if (!b_wr && b_rsel) begin
            if (b_addr !== 32'(b_rd_n / 2)) b_rd_bad++;
            b_rd_n++;
        end
        if (b_done) b_done_n++;
    end

    task automatic clear_mon();
        a_wr_n = 0; a_wr_bad = 0; a_ctrl_n = 0; a_ctrl_bad = 0;
        a_rd_n = 0; a_rd_bad = 0; a_poll_n = 0; a_done_n = 0;
        b_wr_n = 0; b_rd_n = 0; b_rd_bad = 0; b_done_n = 0;
    endtask

    task automatic start_a(input logic [1:0] m);
        @(negedge clk);
        a_mode  = m;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [1:0] m);
        @(negedge clk);
        b_mode  = m;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int max, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((use_b ? b_done : a_done) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_done_wait got=no done_o within %0d cycles exp=done_o", name, max);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_mode = 2'b00; b_mode = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({a_wr, a_rsel, a_busy, a_done, a_timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {a_wr, a_rsel, a_busy, a_done, a_timeout});
        end
        total++;
        if (a_entrada !== 32'h0 || a_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h/%h exp=0/0", a_entrada, a_addr);
        end
        total++;
        if (a_err !== 16'h0 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%h busy_b=%b exp=0 0", a_err, b_busy);
        end
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_echo();
        corrupt_addr = -1; stuck_busy = 1'b0;
        clear_mon();
        start_a(2'b00);
        total++;
        if (a_busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", a_busy); end
        wait_done(1'b0, 300, "full");
        total++;
        if (a_wr_n !== 12 || a_wr_bad !== 0) begin
            bad++; $display("FAIL full_data_writes got=%0d cycles %0d bad exp=12 cycles 0 bad", a_wr_n, a_wr_bad);
        end
        total++;
        if (a_ctrl_n !== 3 || a_ctrl_bad !== 0) begin
            bad++; $display("FAIL full_ctrl_writes got=%0d cycles %0d bad exp=3 cycles 0 bad", a_ctrl_n, a_ctrl_bad);
        end
        total++;
        if (a_poll_n !== 6) begin bad++; $display("FAIL full_poll_cycles got=%0d exp=6", a_poll_n); end
        total++;
        if (a_rd_n !== 12 || a_rd_bad !== 0) begin
            bad++; $display("FAIL full_reads got=%0d cycles %0d bad exp=12 cycles 0 bad", a_rd_n, a_rd_bad);
        end
        total++;
        if (a_err !== 16'd0 || a_timeout !== 1'b0) begin
            bad++; $display("FAIL full_err got=%0d timeout=%b exp=0 0", a_err, a_timeout);
        end
        total++;
        if (a_done_n !== 1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL full_done got=%0d pulses busy=%b exp=1 pulse busy=0", a_done_n, a_busy);
        end
    endtask

    task automatic test_tx_timeout();
        stuck_busy = 1'b1;
        clear_mon();
        start_a(2'b01);
        wait_done(1'b0, 300, "tx_timeout");
        total++;
        if (a_timeout !== 1'b1 || a_poll_n !== 16) begin
            bad++; $display("FAIL tx_timeout got=timeout %b poll %0d exp=1 16", a_timeout, a_poll_n);
        end
        total++;
        if (a_rd_n !== 0 || a_wr_n !== 12 || a_done_n !== 1) begin
            bad++; $display("FAIL tx_no_reads got=rd %0d wr %0d done %0d exp=0 12 1", a_rd_n, a_wr_n, a_done_n);
        end
        repeat (5) @(negedge clk);
        total++;
        if (a_timeout !== 1'b1) begin bad++; $display("FAIL tx_timeout_sticky got=%b exp=1", a_timeout); end
        stuck_busy = 1'b0;
    endtask

    task automatic test_full_corrupt();
        corrupt_addr = 2;
        clear_mon();
        start_a(2'b11);
        total++;
        if (a_timeout !== 1'b0) begin bad++; $display("FAIL corrupt_timeout_clear got=%b exp=0", a_timeout); end
        wait_done(1'b0, 300, "corrupt");
        total++;
        if (a_err !== 16'd1 || a_done_n !== 1 || a_rd_n !== 12) begin
            bad++; $display("FAIL corrupt_err got=err %0d done %0d rd %0d exp=1 1 12", a_err, a_done_n, a_rd_n);
        end
        repeat (5) @(negedge clk);
        total++;
        if (a_err !== 16'd1) begin bad++; $display("FAIL corrupt_err_hold got=%0d exp=1", a_err); end
        corrupt_addr = -1;
    endtask

    task automatic test_read_only();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            v = 32'(i) + 32'hF0;
            mem_b[i] = {24'h0, v[7:0]};
        end
        clear_mon();
        start_b(2'b10);
        wait_done(1'b1, 500, "read_only");
        total++;
        if (b_wr_n !== 0 || b_rd_n !== 64 || b_rd_bad !== 0) begin
            bad++; $display("FAIL ro_bus got=wr %0d rd %0d bad %0d exp=0 64 0", b_wr_n, b_rd_n, b_rd_bad);
        end
        total++;
        if (b_err !== 16'd0 || b_done_n !== 1) begin
            bad++; $display("FAIL ro_echo_err got=err %0d done %0d exp=0 1", b_err, b_done_n);
        end
        for (int i = 0; i < 32; i++) mem_b[i] = 32'(i);
        clear_mon();
        start_b(2'b10);
        wait_done(1'b1, 500, "read_only_unseeded");
        total++;
        if (b_err !== 16'd32) begin bad++; $display("FAIL ro_seed_err got=%0d exp=32", b_err); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        clear_mon();
        start_a(2'b00);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_wr && a_rsel && a_addr == 32'd2) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL mid_reach_word2 got=not reached exp=word 2"); end
        a_reset = 1'b1;
        @(negedge clk);
        total++;
        if ({a_wr, a_rsel, a_busy, a_done, a_timeout} !== 5'b0 || a_addr !== 32'h0 || a_entrada !== 32'h0) begin
            bad++; $display("FAIL mid_reset_outputs got=%b %h %h exp=0", {a_wr, a_rsel, a_busy, a_done, a_timeout}, a_addr, a_entrada);
        end
        a_start = 1'b1;
        @(negedge clk);
        a_reset = 1'b0; a_start = 1'b0;
        @(negedge clk);
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_priority got=busy %b exp=0", a_busy); end
        clear_mon();
        start_a(2'b00);
        wait_done(1'b0, 300, "restart");
        total++;
        if (a_wr_n !== 12 || a_wr_bad !== 0 || a_err !== 16'd0 || a_done_n !== 1) begin
            bad++; $display("FAIL restart_clean got=wr %0d bad %0d err %0d done %0d exp=12 0 0 1", a_wr_n, a_wr_bad, a_err, a_done_n);
        end
    endtask

    task automatic test_start_during_read();
        bit hit;
        clear_mon();
        start_a(2'b00);
        a_mode = 2'b01;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!a_wr && a_rsel && a_busy) begin hit = 1'b1; break; end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL sdr_reach_read got=no read phase exp=read phase"); end
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done(1'b0, 300, "sdr");
        repeat (20) @(negedge clk);
        total++;
        if (a_done_n !== 1 || a_rd_n !== 12 || a_wr_n !== 12 || a_busy !== 1'b0) begin
            bad++; $display("FAIL sdr_single_run got=done %0d rd %0d wr %0d busy %b exp=1 12 12 0", a_done_n, a_rd_n, a_wr_n, a_busy);
        end
        a_mode = 2'b00;
    endtask

    initial begin
        test_reset();
        test_full_echo();
        test_tx_timeout();
        test_full_corrupt();
        test_read_only();
        test_reset_mid();
        test_start_during_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_test_sequencer.md
PERIPH_TEST_SEQUENCER -- requirements
Module: periph_test_sequencer

Interface
REQ-001 Params SHALL be: DEPTH, default 256, words per burst (1..256); DATA_W, default 32, bus data width; WR_HOLD, default 10, cycles each write is held (>=2); RD_HOLD, default 10, cycles each read address is held (>=2).
REQ-002 Params SHALL also be: CTRL_WORD, default 32'h0000_0FD1, control-register command; BUSY_BIT, default 0, busy flag index in salida_i; POLL_TIMEOUT, default 4096, max poll cycles; SEED, default 0, pattern offset.
REQ-003 Ports SHALL be: clk_i  in  1  single clock; all logic on rising edge.
REQ-004 reset_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  begins a run when in IDLE.
REQ-006 mode_i  in  2  00 FULL, 01 TX_ONLY, 10 READ_ONLY, 11 FULL (alias); sampled at start.
REQ-007 salida_i  in  DATA_W  peripheral read data.
REQ-008 wr_i  out  1  peripheral write enable; reg_sel_i  out  1  1=data reg, 0=control reg.
REQ-009 entrada_i  out  DATA_W  write data; addr_i  out  32  word address.
REQ-010 busy_o  out  1  run in progress; done_o  out  1  one-cycle end-of-run pulse; timeout_o  out  1  sticky poll timeout.
REQ-011 err_count_o  out  16  readback mismatches, saturating at 16'hFFFF.

Function
REQ-012 FSM states SHALL be IDLE, WRITE_DATA, WRITE_CTRL, POLL, READ_DATA, DONE.
REQ-013 IDLE: start_i=1 latches mode, clears err_count_o and timeout_o, sets busy_o next cycle; goes to READ_DATA if READ_ONLY, else WRITE_DATA.
REQ-014 pattern(i) SHALL be (i + SEED) mod 2^8, zero-extended to DATA_W.
REQ-015 WRITE_DATA: word i=0..DEPTH-1 holds addr_i=i, entrada_i=pattern(i), wr_i=1, reg_sel_i=1 for exactly WR_HOLD cycles; i advances with no gap.
REQ-016 After word DEPTH-1 SHALL enter WRITE_CTRL: wr_i=1, reg_sel_i=0, addr_i=0, entrada_i=CTRL_WORD for WR_HOLD cycles, then POLL.
REQ-017 POLL: wr_i=0, reg_sel_i=0; on the first cycle salida_i[BUSY_BIT]=0 goes to DONE (TX_ONLY) or READ_DATA (FULL).
REQ-018 POLL SHALL abort to DONE with timeout_o=1 if busy persists POLL_TIMEOUT cycles; readback is skipped.
REQ-019 READ_DATA: wr_i=0, reg_sel_i=1, addr_i=i held RD_HOLD cycles per word; entrada_i=0.
REQ-020 salida_i SHALL be sampled on the last hold cycle of each word; mismatch vs pattern(i) increments err_count_o (saturating).
REQ-021 After word DEPTH-1 SHALL enter DONE: done_o=1 for one cycle, busy_o=0, all bus outputs 0; next state IDLE.
REQ-022 start_i while busy_o=1 SHALL be ignored; mode_i changes mid-run SHALL have no effect.
REQ-023 DEPTH=1 SHALL produce a single word per phase; address counter SHALL not wrap within a run.
REQ-024 err_count_o and timeout_o SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-025 reset_i=1 SHALL force IDLE and zero wr_i, reg_sel_i, entrada_i, addr_i, busy_o, done_o, timeout_o, err_count_o and all counters on the next edge, including mid-run.
REQ-026 reset_i SHALL take priority over start_i in the same cycle.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, mode enum, and default CTRL_WORD constant.
REQ-028 One sub-module, hold_counter (parametrised terminal count, load/expire), SHALL generate WR_HOLD/RD_HOLD/timeout timing.
REQ-029 All outputs SHALL be registered; no combinational path from salida_i to outputs.

Verification
REQ-030 FULL, DEPTH=4, WR_HOLD=3, RD_HOLD=3, peripheral model echoes writes, busy clears after 5 cycles -> 12 data-write cycles, addr 0..3, data 0..3, 3 ctrl cycles with 32'h0FD1, 12 read cycles, err_count_o=0, done_o one pulse.
REQ-031 Same, model corrupts word 2 on read -> err_count_o=1, done_o pulses.
REQ-032 TX_ONLY, busy never clears, POLL_TIMEOUT=16 -> timeout_o=1 after 16 poll cycles, no reg_sel_i=1 reads, done_o pulses.
REQ-033 READ_ONLY, SEED=8'hF0, DEPTH=32 -> no wr_i assertions; expected data wraps F0..FF,00..0F; echo model gives err_count_o=0.
REQ-034 reset_i asserted mid WRITE_DATA at word 2 -> next cycle all outputs 0, state IDLE; new start_i runs cleanly from addr 0.
REQ-035 start_i pulsed during READ_DATA -> run unaffected, exactly one done_o pulse.
